mux41_rr_arb: RTL and testbench
===============================

MUX41_RR_ARB -- requirements
Module: mux41_rr_arb

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8, meaning the maximum consecutive grant cycles before preemption (legal 2..255; used only when the timeout feature is compiled in).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port req  input  4  per-requester request; req[i] is held high for as long as requester i wants the 4:1 mux.
REQ-005 The block SHALL have port sel  output  2  the select for the 4:1 mux, equal to the current or most recent owner index.
REQ-006 The block SHALL have port gnt  output  4  one-hot grant, or all-zero when there is no owner.
REQ-007 The block SHALL have port busy  output  1  high while in state GRANT.

Function
REQ-008 The block SHALL drive sel, gnt and busy directly from registers, with no combinational path from req to any output.
REQ-009 The block SHALL implement two states: IDLE (gnt=0, busy=0) and GRANT (gnt=one-hot owner, busy=1).
REQ-010 The block SHALL keep a 2-bit priority pointer ptr and select the winner as the first i with req[i]=1, searched in order ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-011 In IDLE, at an edge where req!=0, the block SHALL go to GRANT, set owner to the winner, set gnt to onehot(owner) and sel to owner, and set ptr to owner+1 mod 4, giving a 1-cycle req-to-gnt latency.
REQ-012 In IDLE with req=0, the block SHALL hold sel at its last value and hold ptr.
REQ-013 In GRANT with req[owner]=1, the block SHALL hold owner, gnt and sel unchanged, except for the preemption case in REQ-019.
REQ-014 In GRANT with req[owner]=0 and another req bit high, the block SHALL hand off at the same edge to the winner per REQ-010 (ptr already equals owner+1), with no idle bubble and gnt staying one-hot.
REQ-015 In GRANT with req=0, the block SHALL go to IDLE at that edge, with gnt=0 and busy=0 next cycle and sel holding.
REQ-016 When multiple requests rise simultaneously, the block SHALL resolve them strictly by REQ-010 and SHALL NOT starve any requester: each pending requester is granted within 3 handoffs.
REQ-017 The block SHALL ensure gnt is never multi-hot and that sel always equals the index of the set gnt bit whenever gnt!=0.

Reset
REQ-018 While rst_n=0, the block SHALL immediately (asynchronously) force state=IDLE, gnt=0, busy=0, sel=0, ptr=0 and the hold counter to 0, including in the middle of a grant; after release, the first grant follows REQ-011 with ptr=0.

Configuration
REQ-019 With macro MUX41_ARB_TIMEOUT_EN defined, the block SHALL use an 8-bit hold counter that clears on every new grant or handoff and increments each GRANT cycle.
- When the counter equals HOLD_MAX-1 and another req bit is high, the block SHALL hand off per REQ-014 even though req[owner]=1.
- When no other request is pending, the counter SHALL saturate at HOLD_MAX-1 and the grant SHALL be kept.
REQ-020 Without MUX41_ARB_TIMEOUT_EN, the block SHALL contain no hold counter, and an owner SHALL keep the grant until it drops req.

Verification
REQ-021 The bench SHALL cover single request: reset, then req=4'b0100 -> after 1 edge gnt=4'b0100, sel=2'b10, busy=1; then req=0 -> next edge gnt=0, busy=0, sel stays 2'b10.
REQ-022 The bench SHALL cover simultaneous requests after reset: req=4'b1111 held, each owner dropping its bit after 2 grant cycles -> grant order 0,1,2,3 with back-to-back handoffs and no gnt=0 cycle.
REQ-023 The bench SHALL cover round-robin fairness: owner 1 releases while req=4'b1001 -> gnt=4'b1000 (ptr=2 skips 2 and reaches 3 before 0).
REQ-024 The bench SHALL cover the timeout, built with MUX41_ARB_TIMEOUT_EN and HOLD_MAX=4: req[0] held forever and req[2] raised -> owner 0 for exactly 4 cycles, then gnt=4'b0100; a build without the macro keeps gnt=4'b0001 indefinitely.
REQ-025 The bench SHALL cover reset mid-grant: with gnt=4'b0010, pulse rst_n low between edges -> outputs read 0 immediately; after release with req=4'b0011 -> gnt=4'b0001.
REQ-026 The bench SHALL check every cycle that gnt is zero or one-hot, that sel matches gnt when gnt is nonzero, and that busy equals (gnt!=0).

Source files
------------

// File: rtl/mux41_rr_arb.sv
// Registered round-robin arbiter that drives the select of a 4:1 mux.
// Define MUX41_ARB_TIMEOUT_EN to preempt an owner after HOLD_MAX grant cycles.
module mux41_rr_arb #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_r;
  logic [1:0] ptr_r;
  logic [1:0] win_s;
  logic       any_s;
  logic       load_s;
  logic       timeout_s;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux41_rr_arb: HOLD_MAX out of range 2..255");
  end

  // First requester at or after p, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    dbl = {r, r} >> p;
    rot = dbl[3:0];
    if (rot[0]) begin
      off = 2'd0;
    end else if (rot[1]) begin
      off = 2'd1;
    end else if (rot[2]) begin
      off = 2'd2;
    end else begin
      off = 2'd3;
    end
    return p + off;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign any_s = |req;
  assign win_s = rr_pick(req, ptr_r);

`ifdef MUX41_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt_r;

  assign timeout_s = (hold_cnt_r == HOLD_LAST) && ((req & ~onehot(sel)) != 4'b0000);

  // Grant-length counter: restarts on each new owner, saturates at HOLD_LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= 8'd0;
    end else if (load_s) begin
      hold_cnt_r <= 8'd0;
    end else if (state_r == GRANT && hold_cnt_r != HOLD_LAST) begin
      hold_cnt_r <= hold_cnt_r + 8'd1;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // A new owner is loaded from IDLE, or on release/preemption while granted.
  always_comb begin
    load_s = 1'b0;
    if (state_r == IDLE) begin
      load_s = any_s;
    end else begin
      load_s = any_s && (!req[sel] || timeout_s);
    end
  end

  // State, pointer and the registered outputs; sel holds when going idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      sel     <= 2'd0;
      gnt     <= 4'b0000;
      busy    <= 1'b0;
    end else if (load_s) begin
      state_r <= GRANT;
      ptr_r   <= win_s + 2'd1;
      sel     <= win_s;
      gnt     <= onehot(win_s);
      busy    <= 1'b1;
    end else if (state_r == GRANT && !any_s) begin
      state_r <= IDLE;
      gnt     <= 4'b0000;
      busy    <= 1'b0;
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: tb/tb_mux41_rr_arb.sv
// Directed, table-driven bench for mux41_rr_arb (HOLD_MAX=4), with per-cycle
// output invariants; expectations follow MUX41_ARB_TIMEOUT_EN when defined.
module tb_mux41_rr_arb;

`ifdef MUX41_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit inv_en = 1'b0;

  mux41_rr_arb #(.HOLD_MAX(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .sel  (sel),
    .gnt  (gnt),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] s, input logic b, input string n);
    vec_t v;
    v.rst = r; v.req = rq; v.gnt = g; v.sel = s; v.busy = b; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string n, input logic [3:0] g,
                           input logic [1:0] s, input logic b);
    checks++;
    if (gnt !== g || sel !== s || busy !== b) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b, want gnt=%b sel=%0d busy=%b",
               n, gnt, sel, busy, g, s, b);
    end
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Per-cycle invariants on the registered outputs.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if ((gnt & (gnt - 4'd1)) != 4'b0000) begin
        errors++;
        $display("FAIL onehot: gnt=%b is multi-hot", gnt);
      end
      checks++;
      if (gnt != 4'b0000 && gnt != (4'b0001 << sel)) begin
        errors++;
        $display("FAIL sel_match: sel=%0d gnt=%b", sel, gnt);
      end
      checks++;
      if (busy != (gnt != 4'b0000)) begin
        errors++;
        $display("FAIL busy_match: busy=%b gnt=%b", busy, gnt);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;

    // Single request, release, sel holds.
    add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_after_reset");
    add(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, "single_grant");
    add(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_release");
    // All four requesting from reset: 0,1,2,3, two cycles each, no bubble.
    add(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, "all_g0a");
    add(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, "all_g0b");
    add(1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1, "all_g1a");
    add(1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1, "all_g1b");
    add(1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, "all_g2a");
    add(1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, "all_g2b");
    add(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, "all_g3a");
    add(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, "all_g3b");
    add(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, "all_done");
    // Fairness: owner 1 releases with 0 and 3 pending; ptr=2 reaches 3 first.
    add(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, "rr_own1");
    add(1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, "rr_skip_to3");
    add(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, "rr_then0");
    // Owner 0 held forever, requester 2 waiting.
    add(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, "hold_c1");
    add(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, "hold_c2");
    add(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, "hold_c3");
    add(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, "hold_c4");
    for (int i = 0; i < 4; i++)
      add(1'b0, 4'b0101, TMO ? 4'b0100 : 4'b0001, TMO ? 2'd2 : 2'd0, 1'b1,
          $sformatf("hold_after_%0d", i));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        do_reset();
        inv_en = 1'b1;
        check_out($sformatf("%s_reset", vecs[i].name), 4'b0000, 2'd0, 1'b0);
      end
      req = vecs[i].req;
      @(posedge clk);
      #1;
      check_out(vecs[i].name, vecs[i].gnt, vecs[i].sel, vecs[i].busy);
    end

    // Saturated hold counter: a late request preempts at the next edge.
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
    end
    check_out("sat_hold", 4'b0001, 2'd0, 1'b1);
    req = 4'b1001;
    @(posedge clk);
    #1;
    check_out("sat_preempt", TMO ? 4'b1000 : 4'b0001, TMO ? 2'd3 : 2'd0, 1'b1);

    // Reset mid-grant: outputs clear before any clock edge.
    do_reset();
    req = 4'b0010;
    @(posedge clk);
    #1;
    check_out("mid_pre", 4'b0010, 2'd1, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_out("mid_async", 4'b0000, 2'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    req = 4'b0011;
    @(posedge clk);
    #1;
    check_out("mid_after", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000;
    @(posedge clk);
    #1;
    check_out("mid_idle", 4'b0000, 2'd0, 1'b0);

    inv_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
